// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: turns a taken jump from execute into a timed flush window followed by
// a held fetch redirect, or a one-cycle misalignment fault for a target with nonzero low bits.
// Optional build macro BRANCH_STATS_EN adds saturating redirect/fault counters.
module branch_redirect_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_done,
    input  logic        ex_jump,
    input  logic [63:0] ex_target,
    input  logic [63:0] ex_pc,
    output logic        flush_out,
    output logic        stall_out,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    input  logic        redirect_ack,
    output logic        misalign_fault,
    output logic [63:0] fault_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] redirect_count,
    output logic [15:0] fault_count
`endif
);

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {StIdle, StFlush, StReq, StFault} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        stall_q, stall_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [63:0] rpc_q, rpc_d;
    logic [63:0] fpc_q, fpc_d;

    // Next state and next (registered) outputs; results outside IDLE are wrong-path and ignored.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        stall_d    = 1'b0;
        valid_d    = 1'b0;
        misalign_d = 1'b0;
        rpc_d      = rpc_q;
        fpc_d      = fpc_q;
        case (state_q)
            StIdle: begin
                if (ex_done && ex_jump) begin
                    rpc_d = ex_target;
                    if (ex_target[1:0] != 2'b00) begin
                        state_d    = StFault;
                        fpc_d      = ex_pc;
                        misalign_d = 1'b1;
                        flush_d    = 1'b1;
                    end else begin
                        state_d = StFlush;
                        cnt_d   = FlushLoad;
                        flush_d = 1'b1;
                        stall_d = 1'b1;
                    end
                end
            end
            StFlush: begin
                // Counter holds the flush cycles still owed including the current one.
                cnt_d   = cnt_q - 4'd1;
                stall_d = 1'b1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StReq;
                    valid_d = 1'b1;
                end else begin
                    flush_d = 1'b1;
                end
            end
            StReq: begin
                if (redirect_ack) begin
                    state_d = StIdle;
                end else begin
                    valid_d = 1'b1;
                    stall_d = 1'b1;
                end
            end
            StFault: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            rpc_q      <= 64'd0;
            fpc_q      <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            stall_q    <= stall_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            rpc_q      <= rpc_d;
            fpc_q      <= fpc_d;
        end
    end

    assign flush_out      = flush_q;
    assign stall_out      = stall_q;
    assign redirect_valid = valid_q;
    assign redirect_pc    = rpc_q;
    assign misalign_fault = misalign_q;
    assign fault_pc       = fpc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] rcnt_q;
    logic [15:0] fcnt_q;
    logic        accept;
    logic        fault_entry;

    assign accept      = valid_q && redirect_ack;
    assign fault_entry = (state_q == StIdle) && (state_d == StFault);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_q <= 32'd0;
            fcnt_q <= 16'd0;
        end else begin
            if (accept && (rcnt_q != '1)) rcnt_q <= rcnt_q + 32'd1;
            if (fault_entry && (fcnt_q != '1)) fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign redirect_count = rcnt_q;
    assign fault_count    = fcnt_q;
`endif

endmodule

// File: doc/branch_redirect_unit.md
BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

Interface
REQ-001 SHALL provide parameter FLUSH_CYCLES, default 2, number of cycles flush_out is held per taken jump; legal range 1..15.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port ex_done  input  1  execute stage result valid this cycle.
REQ-005 SHALL provide port ex_jump  input  1  jump_signal of the execute result; qualified by ex_done.
REQ-006 SHALL provide port ex_target  input  64  jump/branch target computed by execute.
REQ-007 SHALL provide port ex_pc  input  64  PC of the jumping instruction.
REQ-008 SHALL provide port flush_out  output  1  kill all instructions younger than the jump.
REQ-009 SHALL provide port stall_out  output  1  hold execute; no new results accepted.
REQ-010 SHALL provide port redirect_valid  output  1  new fetch PC offered to fetch.
REQ-011 SHALL provide port redirect_pc  output  64  captured target; stable while redirect_valid is high.
REQ-012 SHALL provide port redirect_ack  input  1  fetch accepts redirect_pc this cycle.
REQ-013 SHALL provide port misalign_fault  output  1  one-cycle pulse for a target with bits [1:0] nonzero.
REQ-014 SHALL provide port fault_pc  output  64  ex_pc of the faulting jump; held until the next fault.

Function
REQ-015 SHALL implement FSM states IDLE, FLUSH, REQ, FAULT; all outputs registered.
REQ-016 In IDLE, ex_done=1 and ex_jump=1 SHALL capture ex_target into redirect_pc and ex_pc into an internal PC register.
REQ-017 From IDLE, a captured target with [1:0]==0 SHALL go to FLUSH and load the flush counter with FLUSH_CYCLES.
REQ-018 From IDLE, a captured target with [1:0]!=0 SHALL go to FAULT and load fault_pc with ex_pc.
REQ-019 In IDLE, ex_done=1 with ex_jump=0, or ex_done=0, SHALL cause no state change and no output activity.
REQ-020 FLUSH SHALL assert flush_out=1 and stall_out=1 and decrement the counter each cycle; leaving FLUSH for REQ when the counter reaches zero.
REQ-021 REQ SHALL assert redirect_valid=1 and stall_out=1 and hold redirect_pc constant until a cycle with redirect_ack=1, then return to IDLE.
REQ-022 In FAULT, misalign_fault=1 and flush_out=1 SHALL be asserted for exactly one cycle, redirect_valid SHALL stay 0, and the FSM SHALL return to IDLE.
REQ-023 Timing: for a jump seen in cycle N, flush_out SHALL be high in cycles N+1..N+FLUSH_CYCLES and redirect_valid SHALL be high from N+FLUSH_CYCLES+1 through the ack cycle inclusive.
REQ-024 ex_done/ex_jump in any state other than IDLE SHALL be ignored as wrong-path results, including in the same cycle as redirect_ack.
REQ-025 redirect_ack while redirect_valid=0 SHALL be ignored.
REQ-026 The unit SHALL hold at most one redirect in flight; no queuing.

Reset
REQ-027 Reset SHALL force state IDLE and set flush_out, stall_out, redirect_valid and misalign_fault to 0, redirect_pc and fault_pc to 0, and the counter to 0.
REQ-028 Reset asserted in FLUSH, REQ or FAULT SHALL abandon the pending redirect; no redirect_valid SHALL appear after reset deasserts.
REQ-029 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-030 With BRANCH_STATS_EN defined, the unit SHALL add output redirect_count (32 bits) and output fault_count (16 bits).
REQ-031 With BRANCH_STATS_EN defined:
- redirect_count SHALL increment on each accepted redirect (redirect_valid and redirect_ack both high).
- fault_count SHALL increment on each FAULT entry.
- Both counters SHALL saturate at all-ones and SHALL clear on reset.
REQ-032 Without BRANCH_STATS_EN, those ports and their counters SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-033 Jump, ack waiting: FLUSH_CYCLES=2, ex_done=1, ex_jump=1, ex_target=0x1000 at N, redirect_ack tied 1 -> flush_out high at N+1 and N+2; redirect_valid high at N+3 with redirect_pc=0x1000; IDLE at N+4.
REQ-034 Delayed ack: as REQ-033 with redirect_ack first high at N+7 -> redirect_valid high N+3..N+7, redirect_pc=0x1000 throughout, stall_out high N+1..N+7.
REQ-035 Misaligned target: ex_target=0x1002, ex_pc=0x800 at N -> misalign_fault=1 and flush_out=1 at N+1 only, fault_pc=0x800, redirect_valid never asserted.
REQ-036 Wrong-path jump: second jump to 0x2000 presented at N+2 and again in the ack cycle -> ignored; only 0x1000 is redirected; IDLE after ack.
REQ-037 Reset mid-flight: reset=1 at N+3 during REQ -> all outputs 0 at N+4; no redirect_valid after reset released; with BRANCH_STATS_EN, redirect_count=0.
